fifo_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing one byte-wide FIFO write port among NUM_REQ producers.

---
 rtl/fifo_write_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter that shares one byte-wide FIFO write port among
// NUM_REQ producers. A grant lasts for one burst, which ends on req_last,
// after MAX_BURST beats, or when the granted producer stalls for STALL_LIMIT
// cycles. A full FIFO only pauses a burst and never ends it, so a write
// never lands in a full FIFO and bytes from different producers never
// interleave inside a burst.
module fifo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int STALL_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_write,
  output logic [7:0]                 fifo_wdata,
  input  logic                       fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  logic          wr_en;
  logic [7:0]    req_byte [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = req_data[i*8 +: 8];
  end

  // Write port and per-requester ready, driven only for the granted requester
  always_comb begin
    req_ready  = '0;
    wr_en      = 1'b0;
    fifo_wdata = 8'h00;
    if (state_q == GRANT) begin
      req_ready[grant_id_q] = ~fifo_full;
      wr_en                 = req_valid[grant_id_q] & ~fifo_full;
      if (wr_en) begin
        fifo_wdata = req_byte[grant_id_q];
      end
    end
  end

  assign fifo_write = wr_en;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == GRANT);

  // Next-state: round-robin pick in IDLE, burst/stall accounting in GRANT
  always_comb begin
    logic          found;
    logic [GW-1:0] idx;
    logic [BW-1:0] beat_inc;
    logic [SW-1:0] stall_inc;
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    found       = 1'b0;
    idx         = grant_id_q;
    beat_inc    = beat_cnt_q + 1'b1;
    stall_inc   = stall_cnt_q + 1'b1;
    if (state_q == IDLE) begin
      // Scan starts just after the last winner so it gets lowest priority
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (idx == GW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant_id_d = idx;
        end
      end
      if (found) begin
        state_d     = GRANT;
        beat_cnt_d  = '0;
        stall_cnt_d = '0;
      end
    end else begin
      if (wr_en) begin
        beat_cnt_d  = beat_inc;
        stall_cnt_d = '0;
        if (req_last[grant_id_q] || (beat_inc == BW'(MAX_BURST))) begin
          state_d = IDLE;
        end
      end else if (!req_valid[grant_id_q]) begin
        stall_cnt_d = stall_inc;
        if (stall_inc == SW'(STALL_LIMIT)) begin
          state_d = IDLE;
        end
      end
    end
  end

  // State registers with synchronous reset; last winner starts as NUM_REQ-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= GW'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Directed scenarios followed by a random run. A small reference model of
// the arbiter predicts grant, ready and write each cycle; bytes the model
// expects to be written are queued and popped when the DUT writes.
// Each producer emits {id, sequence} bytes so order per producer and
// burst ownership can be checked from the written byte itself.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_write;
  logic [7:0]  fifo_wdata;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  int check_count = 0;
  int pass_count  = 0;

  // reference model state
  int m_state;
  int m_gid;
  int m_beat;
  int m_stall;

  logic [5:0] seq [4];
  logic [5:0] exp_seq [4];
  logic [7:0] sb [$];

  // outputs captured by the most recent applyStimulus call
  logic       obs_write;
  logic [7:0] obs_data;
  logic [1:0] obs_gid;
  logic       obs_busy;
  logic [3:0] obs_ready;

  int writes;

  fifo_write_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .STALL_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_write (fifo_write),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end else begin
      pass_count++;
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the model on the rising edge
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic f);
    logic       m_wr;
    logic [3:0] m_rdy;
    logic [7:0] got;
    logic [1:0] src;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    for (int r = 0; r < 4; r++) begin
      req_data[r*8 +: 8] = {2'(r), seq[r]};
    end
    #1;
    m_wr  = (m_state == 1) && v[m_gid] && !f;
    m_rdy = (m_state == 1 && !f) ? (4'b0001 << m_gid) : 4'b0000;
    checkOutput("fifo_write", fifo_write, m_wr);
    checkOutput("req_ready", req_ready, m_rdy);
    checkOutput("busy", busy, (m_state == 1));
    checkOutput("grant_id", grant_id, m_gid);
    checkOutput("no_write_when_full", fifo_write & fifo_full, 0);
    if (m_wr) begin
      sb.push_back({2'(m_gid), seq[m_gid]});
      seq[m_gid] = seq[m_gid] + 1'b1;
    end
    if (fifo_write === 1'b1) begin
      got = fifo_wdata;
      src = got[7:6];
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        checkOutput("wdata", got, sb.pop_front());
      end
      checkOutput("order", got[5:0], exp_seq[src]);
      exp_seq[src] = got[5:0] + 1'b1;
      checkOutput("no_interleave", src, m_gid);
    end else begin
      checkOutput("wdata_idle", fifo_wdata, 8'h00);
    end
    obs_write = fifo_write;
    obs_data  = fifo_wdata;
    obs_gid   = grant_id;
    obs_busy  = busy;
    obs_ready = req_ready;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_gid = 3; m_beat = 0; m_stall = 0;
    end else if (m_state == 0) begin
      for (int i = 1; i <= 4; i++) begin
        if (m_state == 0 && v[(m_gid + i) % 4]) begin
          m_gid   = (m_gid + i) % 4;
          m_state = 1;
          m_beat  = 0;
          m_stall = 0;
        end
      end
    end else if (m_wr) begin
      m_beat++;
      m_stall = 0;
      if (l[m_gid] || m_beat == 4) m_state = 0;
    end else if (!v[m_gid]) begin
      m_stall++;
      if (m_stall == 8) m_state = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int r = 0; r < 4; r++) begin
      seq[r]     = '0;
      exp_seq[r] = '0;
    end
    m_state = 0; m_gid = 3; m_beat = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("reset_gid", obs_gid, 2'd3);
    checkOutput("reset_busy", obs_busy, 0);
    checkOutput("reset_ready", obs_ready, 4'b0000);

    // all requesters valid: grants 0,1,2,3,0 with 4 beats and 1 idle cycle
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b0);
      checkOutput("rr_idle_gap", obs_busy, 0);
      for (int b = 0; b < 4; b++) begin
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        checkOutput("rr_gid", obs_gid, k % 4);
        checkOutput("rr_beat", obs_write, 1);
      end
    end

    // requester 2 sends A1, A2 with last on the second byte
    seq[2]     = 6'h21;
    exp_seq[2] = 6'h21;
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    checkOutput("pkt_byte1", obs_data, 8'hA1);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    checkOutput("pkt_byte2", obs_data, 8'hA2);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("pkt_busy_drop", obs_busy, 0);
    checkOutput("pkt_gid_kept", obs_gid, 2'd2);

    // requester 1 with the FIFO full for 5 cycles mid-burst
    writes = 0;
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(4'b0010, 4'b0000, (c >= 2 && c < 7));
      checkOutput("full_gid", obs_gid, 2'd1);
      if (c >= 2 && c < 7) begin
        checkOutput("full_no_write", obs_write, 0);
        checkOutput("full_no_ready", obs_ready[1], 0);
      end
      writes += int'(obs_write);
    end
    checkOutput("full_beats", writes, 4);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("full_burst_end", obs_busy, 0);

    // requester 3 granted then stalls 8 cycles; pending requester 0 follows
    applyStimulus(4'b1001, 4'b0000, 1'b0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("stall_hold", {obs_busy, obs_gid}, 3'b111);
    end
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("stall_release", obs_busy, 0);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("stall_next_gid", obs_gid, 2'd0);
    checkOutput("stall_next_write", obs_write, 1);

    // reset during beat 2 of requester 0's burst
    rst = 1'b1;
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("rst_beat2_write", obs_write, 1);
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkOutput("rst_outputs", {obs_write, obs_data, obs_ready, obs_busy}, 14'h0);
    checkOutput("rst_gid", obs_gid, 2'd3);
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkOutput("rst_first_winner", obs_gid, 2'd0);

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(4'($urandom), 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) == 0));
    end
    repeat (12) applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
